daq_frame_tx: RTL



---
 rtl/daq_frame_tx_if.sv | 32 +++
 rtl/daq_frame_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_frame_tx_if.sv
// -----------------------------------------------------------------------------
// daq_frame_tx_if
//   Upstream handshake bundle between the sample-processing FSM (master) and
//   the DAQ frame transmitter (slave).
//
//   DIN       16  sample word from the sample FIFO
//   VALID      1  DIN/control qualifier
//   CE         1  pipeline clock enable; 0 = upstream stalled awaiting TXACK
//   CLR_CRC    1  clear the running CRC at this word boundary
//   LAST_WRD   1  final word of the event
//   TXACK      1  one-cycle acknowledge back to the upstream FSM
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface daq_frame_tx_if;
    logic [15:0] DIN;
    logic        VALID;
    logic        CE;
    logic        CLR_CRC;
    logic        LAST_WRD;
    logic        TXACK;

    modport master (
        output DIN, VALID, CE, CLR_CRC, LAST_WRD,
        input  TXACK
    );

    modport slave (
        input  DIN, VALID, CE, CLR_CRC, LAST_WRD,
        output TXACK
    );
endinterface

// File: rtl/daq_frame_tx.sv
// -----------------------------------------------------------------------------
// daq_frame_tx
//   Frames the sequenced DAQ sample words for the optical-link transceiver:
//   idle fill, start-of-frame, payload, end-of-frame. Raises TXACK to release
//   the upstream FSM, keeps a running CRC-16/CCITT over the payload and counts
//   completed frames.
//
//   Optional build macro DAQ_FRAME_CRC_APPEND_EN: appends the CRC as an extra
//   data word (state encoding 7) between the last payload word and EOF.
//
// Ports
//   CLK       in   1   system clock
//   RST       in   1   asynchronous, active-high reset
//   up        slave    DIN/VALID/CE/CLR_CRC/LAST_WRD in, TXACK out
//   LINK_RDY  in   1   transceiver TX reset done (synchronous to CLK)
//   TX_DATA   out 16   word to transceiver
//   TX_K      out  2   charisk per byte, bit0 = low byte
//   CRC       out 16   running CRC
//   FRM_CNT   out 16   completed-frame count
//   ABORT     out  1   sticky: a frame was aborted by LINK_RDY loss
//   TX_STATE  out  3   FSM state, for debug
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module daq_frame_tx #(
    parameter int unsigned PIPE_DEPTH = 2,  // 1..4
    parameter int unsigned SOF_GAP    = 2,  // 0..15
    parameter int unsigned EOF_GAP    = 4   // 1..15
) (
    input  logic           CLK,
    input  logic           RST,
    daq_frame_tx_if.slave  up,
    input  logic           LINK_RDY,
    output logic [15:0]    TX_DATA,
    output logic [1:0]     TX_K,
    output logic [15:0]    CRC,
    output logic [15:0]    FRM_CNT,
    output logic           ABORT,
    output logic [2:0]     TX_STATE
);

    localparam logic [15:0] IDLE_WORD = 16'h50BC;  // K28.5 / D16.2
    localparam logic [15:0] SOF_WORD  = 16'h50FB;  // K27.7
    localparam logic [15:0] EOF_WORD  = 16'h50FD;  // K29.7
    localparam logic [1:0]  K_CTRL    = 2'b01;
    localparam logic [1:0]  K_DATA    = 2'b00;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

    localparam logic [3:0] SOF_LAST = (SOF_GAP > 0) ? 4'(SOF_GAP - 1) : 4'd0;
    localparam logic [3:0] EOF_LAST = (EOF_GAP > 0) ? 4'(EOF_GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SOF  = 3'd1,
        S_GAP1 = 3'd2,
        S_ACK  = 3'd3,
        S_DATA = 3'd4,
        S_EOF  = 3'd5,
        S_GAP2 = 3'd6
`ifdef DAQ_FRAME_CRC_APPEND_EN
        , S_CRC = 3'd7
`endif
    } state_t;

    typedef struct packed {
        logic [15:0] din;
        logic        vld;
        logic        last;
        logic        clr;
    } stage_t;

    // CRC-16/CCITT (poly 0x1021), MSB first, one 16-bit word per call.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [15:0] d);
        logic [15:0] c;
        logic [15:0] s;
        logic        fb;
        c = crc_in;
        s = d;
        for (int unsigned i = 0; i < 16; i++) begin
            fb = c[15] ^ s[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            s  = {s[14:0], 1'b0};
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Input pipeline: shifts only on CE, head is the last stage.
    // ------------------------------------------------------------------
    stage_t stg_in;
    stage_t pipe [PIPE_DEPTH];
    stage_t head;

    assign stg_in = {up.DIN, up.VALID, up.LAST_WRD, up.CLR_CRC};
    assign head   = pipe[PIPE_DEPTH-1];

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_pipe
        if (g == 0) begin : g_first
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)        pipe[0] <= '0;
                else if (up.CE) pipe[0] <= stg_in;
            end
        end else begin : g_next
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)        pipe[g] <= '0;
                else if (up.CE) pipe[g] <= pipe[g-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM. The output registers are loaded on the same edge as the state
    // register with the word belonging to the state being entered, so
    // TX_STATE always labels the word currently on TX_DATA. The last payload
    // word is emitted while still in DATA; eof_pend then forces the exit on
    // the following cycle.
    // ------------------------------------------------------------------
    state_t      state, next_state;
    logic [3:0]  gap_cnt, gap_d;
    logic        eof_pend, eof_pend_d;
    logic [15:0] nxt_data;
    logic [1:0]  nxt_k;
    logic        nxt_ack;
    logic        emit;
    logic        frm_inc;
    logic        set_abort;

    logic [15:0] tx_data_q;
    logic [1:0]  tx_k_q;
    logic        txack_q;
    logic [15:0] crc_q;
    logic [15:0] frm_cnt_q;
    logic        abort_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        gap_d      = gap_cnt;
        eof_pend_d = eof_pend;
        nxt_data   = IDLE_WORD;
        nxt_k      = K_CTRL;
        nxt_ack    = 1'b0;
        emit       = 1'b0;
        frm_inc    = 1'b0;
        set_abort  = 1'b0;

        if (state != S_IDLE && !LINK_RDY) begin
            next_state = S_IDLE;
            eof_pend_d = 1'b0;
            set_abort  = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (LINK_RDY && !up.CE && up.VALID) begin
                        next_state = S_SOF;
                        nxt_data   = SOF_WORD;
                    end
                end
                S_SOF: begin
                    gap_d = '0;
                    if (SOF_GAP == 0) begin
                        next_state = S_ACK;
                        nxt_ack    = 1'b1;
                    end else begin
                        next_state = S_GAP1;
                    end
                end
                S_GAP1: begin
                    if (gap_cnt == SOF_LAST) begin
                        next_state = S_ACK;
                        nxt_ack    = 1'b1;
                    end else begin
                        gap_d = gap_cnt + 4'd1;
                    end
                end
                S_ACK: begin
                    next_state = S_DATA;
                end
                S_DATA: begin
                    if (eof_pend) begin
                        eof_pend_d = 1'b0;
`ifdef DAQ_FRAME_CRC_APPEND_EN
                        next_state = S_CRC;
                        nxt_data   = crc_q;
                        nxt_k      = K_DATA;
`else
                        next_state = S_EOF;
                        nxt_data   = EOF_WORD;
                        frm_inc    = 1'b1;
`endif
                    end else if (up.CE && head.vld) begin
                        emit     = 1'b1;
                        nxt_data = head.din;
                        nxt_k    = K_DATA;
                        if (head.last) eof_pend_d = 1'b1;
                    end
                end
`ifdef DAQ_FRAME_CRC_APPEND_EN
                S_CRC: begin
                    next_state = S_EOF;
                    nxt_data   = EOF_WORD;
                    frm_inc    = 1'b1;
                end
`endif
                S_EOF: begin
                    next_state = S_GAP2;
                    gap_d      = '0;
                end
                S_GAP2: begin
                    if (gap_cnt == EOF_LAST) next_state = S_IDLE;
                    else                     gap_d = gap_cnt + 4'd1;
                end
                default: begin
                    next_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_data_q <= IDLE_WORD;
            tx_k_q    <= K_CTRL;
            txack_q   <= 1'b0;
            crc_q     <= CRC_INIT;
            frm_cnt_q <= '0;
            abort_q   <= 1'b0;
            gap_cnt   <= '0;
            eof_pend  <= 1'b0;
        end else begin
            tx_data_q <= nxt_data;
            tx_k_q    <= nxt_k;
            txack_q   <= nxt_ack;
            gap_cnt   <= gap_d;
            eof_pend  <= eof_pend_d;
            if (frm_inc)   frm_cnt_q <= frm_cnt_q + 16'd1;
            if (set_abort) abort_q   <= 1'b1;
            // A clear on the transmitted word applies before that word is folded in.
            if (emit)                    crc_q <= crc16_word(head.clr ? CRC_INIT : crc_q, head.din);
            else if (up.CE && head.clr)  crc_q <= CRC_INIT;
        end
    end

    assign up.TXACK = txack_q;
    assign TX_DATA  = tx_data_q;
    assign TX_K     = tx_k_q;
    assign CRC      = crc_q;
    assign FRM_CNT  = frm_cnt_q;
    assign ABORT    = abort_q;
    assign TX_STATE = state;

endmodule
